// File: rtl/branch_predictor.sv
// Direct-mapped BTB branch predictor: combinational lookup for the fetch PC,
// training on resolved control flow, mispredict flag and saturating perf counters.
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic        upd_is_jump,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispredict_cnt
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0]       valid_q, valid_d;
  logic [ENTRIES-1:0][1:0]  ctr_q, ctr_d;
  logic [TAG_W-1:0]         tag_q [ENTRIES];
  logic [31:0]              tgt_q [ENTRIES];
  logic                     tag_we, tgt_we;
  logic [31:0]              branch_cnt_q, branch_cnt_d;
  logic [31:0]              mispredict_cnt_q, mispredict_cnt_d;

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             f_hit, u_hit;
  logic             unused_pc;

  assign f_idx = pc_f[IDX_W+1:2];
  assign f_tag = pc_f[IDX_W+1+TAG_W:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[IDX_W+1+TAG_W:IDX_W+2];
  assign unused_pc = ^{pc_f, upd_pc};

  // Lookup reads only registered state, so a same-cycle update is seen next cycle.
  assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign pred_taken  = f_hit && ctr_q[f_idx][1];
  assign pred_target = pred_taken ? tgt_q[f_idx] : pc_f + 32'd4;

  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  assign mispredict = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_pred_target != upd_target)));

  always_comb begin
    valid_d = valid_q;
    ctr_d   = ctr_q;
    tag_we  = 1'b0;
    tgt_we  = 1'b0;
    if (upd_valid && !rst) begin
      if (u_hit) begin
        if (upd_is_jump) begin
          ctr_d[u_idx] = 2'b11;
          tgt_we       = 1'b1;
        end else if (upd_taken) begin
          if (ctr_q[u_idx] != 2'b11) ctr_d[u_idx] = ctr_q[u_idx] + 2'd1;
          tgt_we = 1'b1;
        end else begin
          if (ctr_q[u_idx] != 2'b00) ctr_d[u_idx] = ctr_q[u_idx] - 2'd1;
        end
      end else if (upd_taken || upd_is_jump) begin
        valid_d[u_idx] = 1'b1;
        ctr_d[u_idx]   = upd_is_jump ? 2'b11 : 2'b10;
        tag_we         = 1'b1;
        tgt_we         = 1'b1;
      end
    end
  end

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (upd_valid && (branch_cnt_q != 32'hFFFF_FFFF))
      branch_cnt_d = branch_cnt_q + 32'd1;
    if (mispredict && (mispredict_cnt_q != 32'hFFFF_FFFF))
      mispredict_cnt_d = mispredict_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q          <= '0;
      ctr_q            <= {ENTRIES{2'b01}};
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      valid_q          <= valid_d;
      ctr_q            <= ctr_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  // Tag/target storage is qualified by valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (tag_we) tag_q[u_idx] <= u_tag;
    if (tgt_we) tgt_q[u_idx] <= upd_target;
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor: stimulus pushes expectations,
// a negedge monitor pops and compares against the combinational/counter outputs.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_f = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0, upd_is_jump = 1'b0, upd_taken = 1'b0, upd_pred_taken = 1'b0;
  logic [31:0] upd_pc = '0, upd_target = '0, upd_pred_target = '0;
  logic        mispredict;
  logic [31:0] branch_cnt, mispredict_cnt;

  branch_predictor #(.ENTRIES(64), .TAG_W(8)) dut (
    .clk(clk), .rst(rst), .pc_f(pc_f),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_is_jump(upd_is_jump), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    bit          chk_pred;
    bit          e_taken;
    logic [31:0] e_tgt;
    bit          e_mis;
    bit          chk_cnt;
    logic [31:0] e_bc;
    logic [31:0] e_mc;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  int          n_chk = 0, n_fail = 0;
  logic [31:0] m_bc = '0, m_mc = '0;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      chk({me.nm, ".mispredict"}, {31'd0, mispredict}, {31'd0, me.e_mis});
      if (me.chk_pred) begin
        chk({me.nm, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, me.e_taken});
        chk({me.nm, ".pred_target"}, pred_target, me.e_tgt);
      end
      if (me.chk_cnt) begin
        chk({me.nm, ".branch_cnt"}, branch_cnt, me.e_bc);
        chk({me.nm, ".mispredict_cnt"}, mispredict_cnt, me.e_mc);
      end
    end
  end

  task automatic step(input string nm, input bit r, input logic [31:0] pcf,
                      input bit uv, input bit uj, input logic [31:0] upc,
                      input bit ut, input logic [31:0] utgt,
                      input bit upt, input logic [31:0] uptgt,
                      input bit cp, input bit et, input logic [31:0] etg,
                      input bit em, input bit cc);
    exp_t e;
    @(posedge clk); #1;
    rst = r; pc_f = pcf;
    upd_valid = uv; upd_is_jump = uj; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; upd_pred_taken = upt; upd_pred_target = uptgt;
    e.nm = nm; e.chk_pred = cp; e.e_taken = et; e.e_tgt = etg;
    e.e_mis = em; e.chk_cnt = cc; e.e_bc = m_bc; e.e_mc = m_mc;
    if (!r) q.push_back(e);
    if (r) begin
      m_bc = '0; m_mc = '0;
    end else begin
      if (uv) m_bc = sat_inc(m_bc);
      if (em) m_mc = sat_inc(m_mc);
    end
  endtask

  task automatic look(input string nm, input logic [31:0] pcf, input bit et, input logic [31:0] etg);
    step(nm, 0, pcf, 0, 0, '0, 0, '0, 0, '0, 1, et, etg, 0, 1);
  endtask

  task automatic upd(input string nm, input logic [31:0] pcf, input bit uj, input logic [31:0] upc,
                     input bit ut, input logic [31:0] utgt, input bit upt, input logic [31:0] uptgt,
                     input bit et, input logic [31:0] etg, input bit em);
    step(nm, 0, pcf, 1, uj, upc, ut, utgt, upt, uptgt, 1, et, etg, em, 1);
  endtask

  task automatic rst_cyc();
    step("rst", 1, 32'h100, 0, 0, '0, 0, '0, 0, '0, 0, 0, '0, 0, 0);
  endtask

  initial begin
    rst_cyc(); rst_cyc();
    look("t1", 32'h100, 0, 32'h104);
    // T2: cold taken branch allocates with ctr=10
    upd ("t2_mis",  32'h100, 0, 32'h100, 1, 32'h80, 0, 32'h104, 0, 32'h104, 1);
    look("t2_hit",  32'h100, 1, 32'h80);
    // T3: hysteresis from 11 down
    upd ("t3_tk",   32'h100, 0, 32'h100, 1, 32'h80, 1, 32'h80, 1, 32'h80, 0);
    upd ("t3_nt1",  32'h100, 0, 32'h100, 0, 32'h80, 1, 32'h80, 1, 32'h80, 1);
    look("t3_aft1", 32'h100, 1, 32'h80);
    upd ("t3_nt2",  32'h100, 0, 32'h100, 0, 32'h80, 1, 32'h80, 1, 32'h80, 1);
    look("t3_aft2", 32'h100, 0, 32'h104);
    // counter floor at 00 must hold, not wrap
    upd ("lo_nt1",  32'h100, 0, 32'h100, 0, 32'h0, 0, 32'h104, 0, 32'h104, 0);
    upd ("lo_nt2",  32'h100, 0, 32'h100, 0, 32'h0, 0, 32'h104, 0, 32'h104, 0);
    upd ("lo_tk1",  32'h100, 0, 32'h100, 1, 32'h80, 0, 32'h104, 0, 32'h104, 1);
    look("lo_chk",  32'h100, 0, 32'h104);
    upd ("lo_tk2",  32'h100, 0, 32'h100, 1, 32'h80, 0, 32'h104, 0, 32'h104, 1);
    look("relearn", 32'h100, 1, 32'h80);
    // T4: 0x200 shares index 0 with 0x100 but differs in tag
    look("t4_alias", 32'h200, 0, 32'h204);
    upd ("t4_jal",   32'h200, 1, 32'h200, 1, 32'h400, 0, 32'h204, 0, 32'h204, 1);
    look("t4_evict", 32'h100, 0, 32'h104);
    look("t4_jhit",  32'h200, 1, 32'h400);
    upd ("tgt_mis",  32'h200, 1, 32'h200, 1, 32'h440, 1, 32'h400, 1, 32'h400, 1);
    look("tgt_new",  32'h202, 1, 32'h440);
    step("novalid", 0, 32'h200, 0, 0, 32'h200, 0, 32'h999, 1, 32'h123, 1, 1, 32'h440, 0, 1);
    look("novld_chk", 32'h200, 1, 32'h440);
    // T6: reset discards history and counters
    rst_cyc();
    look("t6_a", 32'h100, 0, 32'h104);
    look("t6_b", 32'h200, 0, 32'h204);
    // T5: same-cycle update and lookup
    upd ("t5_same", 32'h200, 0, 32'h200, 1, 32'h600, 0, 32'h204, 0, 32'h204, 1);
    look("t5_next", 32'h200, 1, 32'h600);
    upd ("nt_miss", 32'h300, 0, 32'h300, 0, 32'h700, 0, 32'h304, 0, 32'h304, 0);
    look("nt_noalloc", 32'h300, 0, 32'h304);
    look("nt_keep",    32'h200, 1, 32'h600);
    look("wrap",       32'hFFFF_FFFC, 0, 32'h0);
    // preload branch counter near the top to exercise saturation
    @(posedge clk); #2;
    force dut.branch_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.branch_cnt_q;
    m_bc = 32'hFFFF_FFFE;
    upd ("sat1", 32'h200, 0, 32'h200, 1, 32'h600, 1, 32'h600, 1, 32'h600, 0);
    upd ("sat2", 32'h200, 0, 32'h200, 1, 32'h600, 1, 32'h600, 1, 32'h600, 0);
    look("sat3", 32'h200, 1, 32'h600);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
